// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial bit-pattern detector with match counter
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  input  logic               d,
  input  logic               d_valid,
  input  logic               clr_cnt,
  output logic               Q,
  output logic               load_err,
  output logic               armed,
  output logic [CNT_W-1:0]   match_cnt
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t             state;
  state_t             state_nxt;
  logic [MAX_LEN-1:0] pat_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   fill_r;
  logic [LEN_W-1:0]   fill_inc;
  logic               ovl_r;
  logic               len_legal;
  logic               accept;
  logic               hit;
  logic               q_nxt;
  logic               err_nxt;

  // load qualification, bit acceptance and the masked pattern compare
  always_comb begin
    len_legal = (len_in != '0) && (len_in <= MAX_LEN_L);
    accept    = (state == RUN) && d_valid && !load;
    hist_nxt  = {hist_r[MAX_LEN-2:0], d};
    fill_inc  = (fill_r >= MAX_LEN_L) ? MAX_LEN_L : fill_r + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len_r);
    end
    hit = accept
          && ((hist_nxt & len_mask) == (pat_r & len_mask))
          && (fill_inc >= len_r);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state: only a legal load arms the detector, only reset disarms it
  always_comb begin
    state_nxt = state;
    if (load && len_legal) begin
      state_nxt = RUN;
    end
  end

  // output decode: values that the output registers take at the next edge
  always_comb begin
    q_nxt   = hit;
    err_nxt = load && !len_legal;
    armed   = (state == RUN);
  end

  // pattern, history, fill, match pulse and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= '0;
      len_r     <= '0;
      ovl_r     <= 1'b0;
      hist_r    <= '0;
      fill_r    <= '0;
      Q         <= 1'b0;
      load_err  <= 1'b0;
      match_cnt <= '0;
    end else begin
      Q        <= q_nxt;
      load_err <= err_nxt;
      if (load && len_legal) begin
        pat_r  <= pat_in;
        len_r  <= len_in;
        ovl_r  <= overlap;
        hist_r <= '0;
        fill_r <= '0;
      end else if (accept) begin
        hist_r <= hist_nxt;
        // non-overlapping mode restarts the fill so no bit is reused
        fill_r <= (hit && !ovl_r) ? '0 : fill_inc;
      end
      if (clr_cnt) begin
        match_cnt <= '0;
      end else if (hit && (match_cnt != CNT_MAX)) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap;
  logic       d;
  logic       d_valid;
  logic       clr_cnt;

  logic       q_a, err_a, armed_a;
  logic [7:0] cnt_a;
  logic       q_b, err_b, armed_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .load(load), .pat_in(pat_in), .len_in(len_in),
    .overlap(overlap), .d(d), .d_valid(d_valid), .clr_cnt(clr_cnt),
    .Q(q_a), .load_err(err_a), .armed(armed_a), .match_cnt(cnt_a)
  );

  seq_detector_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .load(load), .pat_in(pat_in), .len_in(len_in),
    .overlap(overlap), .d(d), .d_valid(d_valid), .clr_cnt(clr_cnt),
    .Q(q_b), .load_err(err_b), .armed(armed_b), .match_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: accepted bits since the last restart, compared as a window
  bit   m_bits[$];
  bit   m_valid = 1'b0;
  bit   m_armed;
  int   m_len;
  logic [7:0] m_pat;
  bit   m_ovl;
  bit   exp_q, exp_err;
  int   exp_cnt_a, exp_cnt_b;

  always @(posedge clk) begin
    bit match;
    if (rst) begin
      m_valid = 1'b1;
      m_armed = 1'b0;
      m_bits.delete();
      m_len = 0; m_pat = '0; m_ovl = 1'b0;
      exp_q = 1'b0; exp_err = 1'b0;
      exp_cnt_a = 0; exp_cnt_b = 0;
    end else begin
      match   = 1'b0;
      exp_err = 1'b0;
      if (load) begin
        if (len_in >= 1 && len_in <= 8) begin
          m_pat = pat_in; m_len = int'(len_in); m_ovl = overlap;
          m_bits.delete();
          m_armed = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
      end else if (m_armed && d_valid) begin
        m_bits.push_back(d);
        while (m_bits.size() > 8) void'(m_bits.pop_front());
        if (m_bits.size() >= m_len) begin
          match = 1'b1;
          for (int k = 0; k < m_len; k++) begin
            if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k]) match = 1'b0;
          end
        end
        if (match && !m_ovl) m_bits.delete();
      end
      exp_q = match;
      if (clr_cnt) begin
        exp_cnt_a = 0; exp_cnt_b = 0;
      end else if (match) begin
        if (exp_cnt_a < 255) exp_cnt_a++;
        if (exp_cnt_b < 3)   exp_cnt_b++;
      end
    end
  end

  // cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (m_valid) begin
      check("q_a", q_a, exp_q);
      check("err_a", err_a, exp_err);
      check("armed_a", armed_a, m_armed);
      check("cnt_a", cnt_a, exp_cnt_a);
      check("q_b", q_b, exp_q);
      check("err_b", err_b, exp_err);
      check("armed_b", armed_b, m_armed);
      check("cnt_b", cnt_b, exp_cnt_b);
    end
  end

  // stimulus helpers; each call is one clock cycle of input
  int          step_n;
  logic [31:0] qlog;

  task automatic tick();
    @(negedge clk);
    if (step_n >= 1 && step_n <= 32 && q_a === 1'b1) qlog[step_n-1] = 1'b1;
    step_n++;
  endtask

  task automatic begin_log();
    step_n = 0;
    qlog   = '0;
  endtask

  task automatic clear_in();
    rst = 1'b0; load = 1'b0; d = 1'b0; d_valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic idle();
    tick(); clear_in();
  endtask

  task automatic do_rst();
    tick(); clear_in(); rst = 1'b1;
  endtask

  task automatic bit_in(input logic b);
    tick(); clear_in(); d = b; d_valid = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic o);
    tick(); clear_in(); load = 1'b1; pat_in = p; len_in = l; overlap = o;
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; pat_in = '0; len_in = '0; overlap = 1'b0;
    d = 1'b0; d_valid = 1'b0; clr_cnt = 1'b0;
    step_n = 0; qlog = '0;

    // reset state
    do_rst(); idle();
    check("rst_q", q_a, 1'b0);
    check("rst_err", err_a, 1'b0);
    check("rst_armed", armed_a, 1'b0);
    check("rst_cnt", cnt_a, 0);

    // 010 overlapping on 01010
    do_load(8'b010, 4'd3, 1'b1);
    begin_log();
    bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0); idle();
    check("ovl_qlog", qlog, 32'h14);
    check("ovl_cnt", cnt_a, 2);
    check("ovl_armed", armed_a, 1'b1);

    // 010 non-overlapping on 01010
    do_rst(); do_load(8'b010, 4'd3, 1'b0);
    begin_log();
    bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0); idle();
    check("novl_qlog", qlog, 32'h04);
    check("novl_cnt", cnt_a, 1);

    // pattern spanning bubbles
    do_rst(); do_load(8'b010, 4'd3, 1'b1);
    begin_log();
    bit_in(0); idle(); idle(); idle();
    bit_in(1); idle(); idle(); idle();
    bit_in(0); idle(); idle();
    check("gap_qlog", qlog, 32'h100);

    // illegal loads
    do_rst(); idle();
    do_load(8'b010, 4'd0, 1'b1); idle();
    check("err_len0", err_a, 1'b1);
    do_load(8'b010, 4'd9, 1'b1); idle();
    check("err_len9", err_a, 1'b1);
    check("err_armed", armed_a, 1'b0);
    idle();
    check("err_oneshot", err_a, 1'b0);
    begin_log();
    bit_in(0); bit_in(1); bit_in(0); idle();
    check("idle_noq", qlog, 32'h0);

    // load colliding with a data bit, then 11 detection in both modes
    for (int m = 1; m >= 0; m--) begin
      do_rst(); do_load(8'b010, 4'd3, 1'b1);
      bit_in(0); bit_in(1);
      begin_log();
      tick(); clear_in(); load = 1'b1; pat_in = 8'b11; len_in = 4'd2;
      overlap = 1'(m); d = 1'b0; d_valid = 1'b1;
      bit_in(1); bit_in(1); bit_in(1); idle();
      check(m ? "reload_ovl" : "reload_novl", qlog, m ? 32'h0C : 32'h04);
    end

    // len=1 with counter saturation, clear versus increment, mid-stream reset
    do_rst(); do_load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) bit_in(1);
    idle();
    check("sat_cnt_b", cnt_b, 2'd3);
    check("sat_cnt_a", cnt_a, 5);
    tick(); clear_in(); d = 1'b1; d_valid = 1'b1; clr_cnt = 1'b1;
    idle();
    check("clr_cnt_b", cnt_b, 2'd0);
    check("clr_q_b", q_b, 1'b1);
    bit_in(1); bit_in(1);
    tick(); clear_in(); rst = 1'b1; d = 1'b1; d_valid = 1'b1;
    idle();
    check("mrst_q", q_a, 1'b0);
    check("mrst_armed", armed_a, 1'b0);
    check("mrst_cnt", cnt_a, 0);
    check("mrst_err", err_a, 1'b0);
    begin_log();
    bit_in(1); bit_in(1); idle();
    check("mrst_idle_noq", qlog, 32'h0);

    // randomized traffic against the model
    for (int r = 0; r < 12; r++) begin
      do_rst();
      do_load(8'($urandom), 4'($urandom_range(1, 4)), 1'($urandom));
      for (int c = 0; c < 250; c++) begin
        int sel;
        sel = $urandom_range(0, 199);
        tick(); clear_in();
        d = 1'($urandom);
        d_valid = ($urandom_range(0, 9) < 7);
        if (sel < 4) begin
          load = 1'b1;
          pat_in = 8'($urandom);
          len_in = 4'($urandom_range(0, 10));
          overlap = 1'($urandom);
        end else if (sel < 8) begin
          clr_cnt = 1'b1;
        end else if (sel == 8) begin
          rst = 1'b1;
        end
      end
    end

    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
